// File: rtl/cpu_clk_pkg.sv
// rtl/cpu_clk_pkg.sv - shared types and constants for the CPU clock-enable generator
//
// Purpose : FSM state encoding, counter widths and the divider mask helper
//           used by cpu_step_clk_gen.
// Ports   : none (package).
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STEP_IDLE  = 2'd1,
    STEP_PULSE = 2'd2
  } step_state_t;

  localparam int CE_CNT_W = 16;
  localparam int DIV_W    = 32;

  // Mask with the low 'bits' bits set; the divider ticks when all of them are 1.
  function automatic logic [DIV_W-1:0] low_mask(input int bits);
    logic [DIV_W-1:0] one;
    one = 1;
    return (one << bits) - one;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronizer, stability debounce and rising-edge detect for one button
//
// Purpose : Brings an asynchronous, bouncy button into the clk domain and only
//           accepts a new level once it has been stable for 2^DEB_CNT cycles.
// Ports   : clk   - clock
//           rst_n - asynchronous active-low reset
//           din   - raw asynchronous button input
//           dout  - debounced level
//           rise  - one-cycle pulse in the first cycle dout is high
module btn_debounce #(
  parameter int DEB_CNT = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic               sync_1;
  logic               sync_2;
  logic [DEB_CNT-1:0] stab_cnt;

  // The counter only runs while the synced input disagrees with the accepted
  // level; any bounce back to the accepted level restarts the stability window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      stab_cnt <= '0;
      dout     <= 1'b0;
      rise     <= 1'b0;
    end else begin
      sync_1 <= din;
      sync_2 <= sync_1;
      rise   <= 1'b0;
      if (sync_2 == dout) begin
        stab_cnt <= '0;
      end else if (&stab_cnt) begin
        dout     <= sync_2;
        stab_cnt <= '0;
        rise     <= sync_2;
      end else begin
        stab_cnt <= stab_cnt + DEB_CNT'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_step_clk_gen.sv
// rtl/cpu_step_clk_gen.sv - CPU clock-enable source with 2^N run rates and debounced single-step
//
// Purpose : Produces a one-cycle cpu_ce pulse either from a free-running 2^N
//           divider (run mode) or once per debounced button press (step mode),
//           plus a 50% cpu_clk level and a count of issued enables.
// Ports   : clk       - board clock, sole clock domain
//           rst_n     - asynchronous active-low reset
//           SW15      - async rate select, 1 = slow (2^SLOW_DIV), 0 = fast (2^FAST_DIV)
//           step_mode - async mode select, 1 = single-step, 0 = free run
//           btn_step  - async active-high step button (bouncy)
//           cpu_ce    - one-cycle CPU clock-enable pulse
//           cpu_clk   - toggles after every cpu_ce
//           ce_count  - number of cpu_ce pulses since reset, wrapping
module cpu_step_clk_gen
  import cpu_clk_pkg::*;
#(
  parameter int FAST_DIV = 18,
  parameter int SLOW_DIV = 25,
  parameter int DEB_CNT  = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SW15,
  input  logic                step_mode,
  input  logic                btn_step,
  output logic                cpu_ce,
  output logic                cpu_clk,
  output logic [CE_CNT_W-1:0] ce_count
);

  localparam logic [DIV_W-1:0] FAST_MASK = low_mask(FAST_DIV);
  localparam logic [DIV_W-1:0] SLOW_MASK = low_mask(SLOW_DIV);

  logic             sw_meta;
  logic             sw_s;
  logic             step_meta;
  logic             step_s;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] sel_mask;
  logic             tick;
  logic             btn_db;
  logic             btn_rise;
  logic             press;
  step_state_t      state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta   <= 1'b0;
      sw_s      <= 1'b0;
      step_meta <= 1'b0;
      step_s    <= 1'b0;
    end else begin
      sw_meta   <= SW15;
      sw_s      <= sw_meta;
      step_meta <= step_mode;
      step_s    <= step_meta;
    end
  end

  btn_debounce #(
    .DEB_CNT(DEB_CNT)
  ) u_btn_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (btn_step),
    .dout (btn_db),
    .rise (btn_rise)
  );

  // rise is only ever asserted together with a high accepted level; gating on
  // both ties a step strictly to an accepted press.
  assign press = btn_rise & btn_db;

  // The divider never restarts on a rate change, so the first tick at the new
  // rate may arrive early; every later tick is on the new 2^N grid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  assign sel_mask = sw_s ? SLOW_MASK : FAST_MASK;
  assign tick     = ((div & sel_mask) == sel_mask);

  // A tick seen in the cycle RUN hands over to STEP_IDLE still produces a pulse;
  // a press seen in the cycle step mode is left is dropped in favour of RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      cpu_ce <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          cpu_ce <= tick;
          if (step_s) state <= STEP_IDLE;
        end
        STEP_IDLE: begin
          cpu_ce <= 1'b0;
          if (!step_s)    state <= RUN;
          else if (press) state <= STEP_PULSE;
        end
        STEP_PULSE: begin
          cpu_ce <= 1'b1;
          state  <= step_s ? STEP_IDLE : RUN;
        end
        default: begin
          cpu_ce <= 1'b0;
          state  <= RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_clk  <= 1'b0;
      ce_count <= '0;
    end else if (cpu_ce) begin
      cpu_clk  <= ~cpu_clk;
      ce_count <= ce_count + CE_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_step_clk_gen.sv
// tb/tb_cpu_step_clk_gen.sv - self-checking bench for cpu_step_clk_gen
module tb_cpu_step_clk_gen;

  localparam int DEB_LEN = 8;  // 2^DEB_CNT with DEB_CNT=3

  logic        clk = 1'b0;
  logic        rst_n, SW15, step_mode, btn_step;
  logic        cpu_ce, cpu_clk;
  logic [15:0] ce_count;
  logic        rst2_n;
  logic        cpu_ce2, cpu_clk2;
  logic [15:0] ce_count2;

  always #5 clk = ~clk;

  cpu_step_clk_gen #(.FAST_DIV(2), .SLOW_DIV(4), .DEB_CNT(3)) dut (
    .clk(clk), .rst_n(rst_n), .SW15(SW15), .step_mode(step_mode), .btn_step(btn_step),
    .cpu_ce(cpu_ce), .cpu_clk(cpu_clk), .ce_count(ce_count)
  );

  // Ticks every cycle so the 16-bit count wrap is reachable quickly.
  cpu_step_clk_gen #(.FAST_DIV(0), .SLOW_DIV(0), .DEB_CNT(1)) dut_wrap (
    .clk(clk), .rst_n(rst2_n), .SW15(1'b0), .step_mode(1'b0), .btn_step(1'b0),
    .cpu_ce(cpu_ce2), .cpu_clk(cpu_clk2), .ce_count(ce_count2)
  );

  int compared   = 0;
  int mismatched = 0;
  int n;          // clock edges since the last reset release
  int exp_cnt;    // model count of cpu_ce pulses
  int ce_hi = 0;  // observed cpu_ce high cycles
  bit chk_on;
  bit sw_at   [8192];
  bit step_at [8192];
  bit wave[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Inputs set after edge k reach the FSM at edge k+3 (two sync flops).
  // cpu_ce after edge k follows the divider grid only if the FSM was in RUN at
  // edge k, i.e. it saw run mode at edge k-1.
  function automatic bit exp_ce(input int k);
    bit slow, stepping;
    int p;
    slow     = (k >= 3) ? sw_at[k-3]   : 1'b0;
    stepping = (k >= 4) ? step_at[k-4] : 1'b0;
    p        = slow ? 16 : 4;
    return !stepping && (k % p == 0);
  endfunction

  // Number of accepted presses: a run of equal levels is accepted once it is
  // at least DEB_LEN long and differs from the accepted level.
  function automatic int count_steps(input bit w[$]);
    int steps = 0;
    bit db = 1'b0;
    int i = 0;
    int j;
    while (i < w.size()) begin
      j = i;
      while (j < w.size() && w[j] == w[i]) j++;
      if ((j - i) >= DEB_LEN && w[i] != db) begin
        db = w[i];
        if (db) steps++;
      end
      i = j;
    end
    return steps;
  endfunction

  task automatic cyc();
    bit e;
    if (n >= 8191) begin
      $display("FAIL n_bound: edge index %0d exceeds model table", n);
      $fatal(1);
    end
    sw_at[n]   = SW15;
    step_at[n] = step_mode;
    @(posedge clk);
    n++;
    #1;
    if (cpu_ce) ce_hi++;
    e = exp_ce(n);
    if (chk_on) begin
      check("ce", cpu_ce, e);
      check("ce_count", ce_count, exp_cnt & 'hFFFF);
      check("cpu_clk", cpu_clk, exp_cnt & 1);
    end
    exp_cnt += e;
  endtask

  task automatic drive_btn(input bit w[$]);
    foreach (w[i]) begin
      btn_step = w[i];
      cyc();
    end
  endtask

  task automatic press_phase(input bit w[$]);
    int steps, hi0, cnt0;
    steps  = count_steps(w);
    chk_on = 1'b0;
    hi0    = ce_hi;
    cnt0   = exp_cnt;
    drive_btn(w);
    check("step_pulses", ce_hi - hi0, steps);
    check("step_count", ce_count, (cnt0 + steps) & 'hFFFF);
    exp_cnt = cnt0 + steps;
    chk_on  = 1'b1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    n       = 0;
    exp_cnt = 0;
    chk_on  = 1'b1;
  endtask

  initial begin
    bit lvl;
    bit found;
    int cnt;
    rst_n = 1'b0; rst2_n = 1'b0;
    SW15 = 1'b0; step_mode = 1'b0; btn_step = 1'b0;
    n = 0; exp_cnt = 0; chk_on = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ce", cpu_ce, 0);
    check("rst_clk", cpu_clk, 0);
    check("rst_count", ce_count, 0);
    check("rst_wrap_count", ce_count2, 0);

    // Fast run: pulse every 4 edges, ten pulses by edge 41.
    release_reset();
    while (n < 41) cyc();
    check("run_count_10", ce_count, 10);
    check("run_clk_even", cpu_clk, 0);

    // Random rate and mode changes; first segment forces the 0->1 rate switch.
    SW15 = 1'b1;
    repeat ($urandom_range(20, 70)) cyc();
    for (int s = 0; s < 10; s++) begin
      SW15      = 1'($urandom_range(0, 1));
      step_mode = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(20, 70)) cyc();
    end
    SW15 = 1'b0;

    // Step mode without a press: output silent, count frozen.
    step_mode = 1'b1;
    repeat (200) cyc();

    // Bouncing press then a long hold, release, one clean press.
    wave = {};
    for (int s = 0; s < 10; s++) repeat (3) wave.push_back(s % 2 == 0);
    repeat (40) wave.push_back(1'b1);
    repeat (20) wave.push_back(1'b0);
    repeat (12) wave.push_back(1'b1);
    repeat (25) wave.push_back(1'b0);
    press_phase(wave);
    repeat (10) cyc();

    // Random button activity.
    for (int r = 0; r < 3; r++) begin
      wave = {};
      lvl  = 1'b1;
      repeat (16) begin
        repeat ($urandom_range(2, 14)) wave.push_back(lvl);
        lvl = !lvl;
      end
      repeat (25) wave.push_back(1'b0);
      press_phase(wave);
    end

    // Press accepted in the same cycle the FSM sees step mode drop: ignored.
    while (n % 4 != 2) cyc();
    btn_step = 1'b1;
    repeat (8) cyc();
    step_mode = 1'b0;
    repeat (40) cyc();
    btn_step = 1'b0;
    repeat (20) cyc();

    // Reset while a step pulse is on the output.
    step_mode = 1'b1;
    repeat (10) cyc();
    chk_on   = 1'b0;
    btn_step = 1'b1;
    found    = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (cpu_ce) found = 1'b1;
    end
    check("step_pulse_seen", found, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ce", cpu_ce, 0);
    check("rst_mid_clk", cpu_clk, 0);
    check("rst_mid_count", ce_count, 0);
    btn_step = 1'b0; step_mode = 1'b0; SW15 = 1'b0;
    repeat (3) @(posedge clk);
    release_reset();
    repeat (60) cyc();

    // Count wrap 0xFFFF -> 0x0000.
    @(negedge clk);
    rst2_n = 1'b1;
    cnt    = 0;
    found  = 1'b0;
    while (cnt < 70000 && !found) begin
      @(posedge clk);
      #1;
      cnt++;
      if (ce_count2 == 16'hFFFF) found = 1'b1;
    end
    check("wrap_reached", found, 1);
    check("wrap_edges", cnt, 65536);
    check("wrap_ce", cpu_ce2, 1);
    @(posedge clk);
    #1;
    check("wrap_zero", ce_count2, 0);
    check("wrap_clk", cpu_clk2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
